cmp_bubble_sorter: RTL and testbench

//  Sorts a block of N unsigned 4-bit words into ascending order using one shared
//  bit4_comparator instance, one comparison per clock.

---
 rtl/cmp_pkg.sv | 19 +
 rtl/bit4_comparator.sv | 27 ++
 rtl/cmp_bubble_sorter.sv | 208 ++++++++++++++++++++
 tb/tb_cmp_bubble_sorter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cmp_pkg
//  Description : Shared word width and FSM state encoding for the compare-based
//                bubble sorter and its magnitude comparator.
//  Revision    : 1.0 - initial release
// ============================================================================
package cmp_pkg;

   localparam int CMP_W = 4;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SORT  = 2'd1,
      DRAIN = 2'd2
   } sort_state_t;

endpackage : cmp_pkg
`default_nettype wire

// File: rtl/bit4_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : bit4_comparator
//  Description : Unsigned magnitude comparator for two CMP_W-bit words.
//                Exactly one of the three outputs is high at any time.
//  Ports       : i_a, i_b  - unsigned operands
//                o_gt      - i_a >  i_b
//                o_eq      - i_a == i_b
//                o_lt      - i_a <  i_b
//  Revision    : 1.0 - initial release
// ============================================================================
module bit4_comparator
   import cmp_pkg::*;
(
   input  logic [CMP_W-1:0] i_a,
   input  logic [CMP_W-1:0] i_b,
   output logic             o_gt,
   output logic             o_eq,
   output logic             o_lt
);

   assign o_gt = (i_a >  i_b);
   assign o_eq = (i_a == i_b);
   assign o_lt = (i_a <  i_b);

endmodule : bit4_comparator
`default_nettype wire

// File: rtl/cmp_bubble_sorter.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_bubble_sorter
//  Description : Accepts a block of N unsigned words over a valid/ready input,
//                bubble-sorts them in place with a single shared comparator
//                (one compare per clock, early exit on a swap-free pass), then
//                streams them out smallest first over a valid/ready output.
//  Ports       : clk, rst              - clock, async active-high reset
//                in_valid/in_ready     - input handshake, in_data word
//                out_valid/out_ready   - output handshake, out_data word
//                out_last              - marks the N-th (largest) output word
//                busy                  - high while sorting or draining
//                swap_count            - swaps performed in current/last block
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_bubble_sorter
   import cmp_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1,
   localparam int CW = $clog2(N*(N-1)/2 + 1)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CMP_W-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CMP_W-1:0] out_data,
   output logic             out_last,
   output logic             busy,
   output logic [CW-1:0]    swap_count
);

   localparam logic [IW-1:0] c_LAST_IDX = IW'(N-1);
   localparam logic [IW-1:0] c_LAST_J   = IW'(N-2);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   sort_state_t      r_state,   w_state_nxt;
   logic [CMP_W-1:0] r_buf      [N];
   logic [CMP_W-1:0] w_buf_nxt  [N];
   logic [IW-1:0]    r_wr_idx,  w_wr_idx_nxt;
   logic [IW-1:0]    r_rd_idx,  w_rd_idx_nxt;
   logic [IW-1:0]    r_j,       w_j_nxt;
   logic [IW-1:0]    r_pass,    w_pass_nxt;
   logic             r_swapped, w_swapped_nxt;
   logic [CW-1:0]    r_swap_cnt, w_swap_cnt_nxt;

   // ------------------------------------------------------------------------
   // Shared comparator on the adjacent pair buf[j], buf[j+1]
   // ------------------------------------------------------------------------
   logic [IW-1:0]    w_j1;
   logic [CMP_W-1:0] w_cmp_a;
   logic [CMP_W-1:0] w_cmp_b;
   logic             w_gt;
   logic             w_eq;
   logic             w_lt;
   logic             w_do_swap;

   assign w_j1    = r_j + IW'(1);
   assign w_cmp_a = r_buf[r_j];
   assign w_cmp_b = r_buf[w_j1];

   bit4_comparator u_cmp (
      .i_a  (w_cmp_a),
      .i_b  (w_cmp_b),
      .o_gt (w_gt),
      .o_eq (w_eq),
      .o_lt (w_lt)
   );

   // Swap only on strictly-greater; ties stay put so the sort is stable.
   assign w_do_swap = w_gt & ~w_eq & ~w_lt;

   // ------------------------------------------------------------------------
   // Next-state and decoded outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_buf_nxt      = r_buf;
      w_wr_idx_nxt   = r_wr_idx;
      w_rd_idx_nxt   = r_rd_idx;
      w_j_nxt        = r_j;
      w_pass_nxt     = r_pass;
      w_swapped_nxt  = r_swapped;
      w_swap_cnt_nxt = r_swap_cnt;
      in_ready       = 1'b0;
      out_valid      = 1'b0;
      busy           = 1'b0;

      case (r_state)
         LOAD: begin
            // Held low while reset is asserted; rises as soon as it releases.
            in_ready = ~rst;
            if (in_valid) begin
               w_buf_nxt[r_wr_idx] = in_data;
               if (r_wr_idx == '0) begin
                  w_swap_cnt_nxt = '0;
               end
               if (r_wr_idx == c_LAST_IDX) begin
                  w_state_nxt   = SORT;
                  w_wr_idx_nxt  = '0;
                  w_pass_nxt    = '0;
                  w_j_nxt       = '0;
                  w_swapped_nxt = 1'b0;
               end else begin
                  w_wr_idx_nxt = r_wr_idx + IW'(1);
               end
            end
         end

         SORT: begin
            busy = 1'b1;
            if (w_do_swap) begin
               w_buf_nxt[r_j]  = w_cmp_b;
               w_buf_nxt[w_j1] = w_cmp_a;
               w_swapped_nxt   = 1'b1;
               w_swap_cnt_nxt  = r_swap_cnt + CW'(1);
            end
            // Pass p ends at j = N-2-p. The swap made this cycle counts
            // towards the pass, hence the OR with w_do_swap.
            if (r_j == (c_LAST_J - r_pass)) begin
               if (!(r_swapped | w_do_swap) || (r_pass == c_LAST_J)) begin
                  w_state_nxt  = DRAIN;
                  w_rd_idx_nxt = '0;
               end else begin
                  w_pass_nxt    = r_pass + IW'(1);
                  w_j_nxt       = '0;
                  w_swapped_nxt = 1'b0;
               end
            end else begin
               w_j_nxt = r_j + IW'(1);
            end
         end

         DRAIN: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               if (r_rd_idx == c_LAST_IDX) begin
                  w_state_nxt  = LOAD;
                  w_rd_idx_nxt = '0;
               end else begin
                  w_rd_idx_nxt = r_rd_idx + IW'(1);
               end
            end
         end

         default: begin
            w_state_nxt = LOAD;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= LOAD;
         r_wr_idx   <= '0;
         r_rd_idx   <= '0;
         r_j        <= '0;
         r_pass     <= '0;
         r_swapped  <= 1'b0;
         r_swap_cnt <= '0;
         for (int i = 0; i < N; i++) begin
            r_buf[i] <= '0;
         end
      end else begin
         r_state    <= w_state_nxt;
         r_wr_idx   <= w_wr_idx_nxt;
         r_rd_idx   <= w_rd_idx_nxt;
         r_j        <= w_j_nxt;
         r_pass     <= w_pass_nxt;
         r_swapped  <= w_swapped_nxt;
         r_swap_cnt <= w_swap_cnt_nxt;
         for (int i = 0; i < N; i++) begin
            r_buf[i] <= w_buf_nxt[i];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Registered output word. It is loaded from the next-cycle buffer and read
   // index so it is already valid on the first DRAIN cycle, including when
   // the final compare of SORT swapped the word being presented.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data <= '0;
         out_last <= 1'b0;
      end else if (w_state_nxt == DRAIN) begin
         out_data <= w_buf_nxt[w_rd_idx_nxt];
         out_last <= (w_rd_idx_nxt == c_LAST_IDX);
      end else begin
         out_data <= '0;
         out_last <= 1'b0;
      end
   end

   assign swap_count = r_swap_cnt;

endmodule : cmp_bubble_sorter
`default_nettype wire

// File: tb/tb_cmp_bubble_sorter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmp_bubble_sorter
//  Description : Self-checking bench for cmp_bubble_sorter (N=4). Directed
//                blocks plus random blocks, compared against a reference
//                computed from inversion counts and a value histogram.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp_bubble_sorter;

   localparam int N  = 4;
   localparam int CW = $clog2(N*(N-1)/2 + 1);

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    in_data;
   logic          out_valid;
   logic          out_ready;
   logic [3:0]    out_data;
   logic          out_last;
   logic          busy;
   logic [CW-1:0] swap_count;

   int total;
   int bad;

   logic [3:0] blk        [N];
   int         exp_sorted [N];
   int         exp_swaps;
   int         exp_cyc;

   cmp_bubble_sorter #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .busy       (busy),
      .swap_count (swap_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Reference: bubble sort swaps = inversion count; passes needed = largest
   // number of greater elements preceding any element, plus one confirming
   // pass, capped at N-1; sorted order from a histogram.
   task automatic compute_ref();
      int hist [16];
      int d, maxd, passes, pos;
      exp_swaps = 0;
      maxd      = 0;
      for (int i = 0; i < N; i++) begin
         d = 0;
         for (int k = 0; k < i; k++) if (blk[k] > blk[i]) d++;
         exp_swaps += d;
         if (d > maxd) maxd = d;
      end
      passes  = (maxd + 1 < N - 1) ? maxd + 1 : N - 1;
      exp_cyc = 0;
      for (int p = 0; p < passes; p++) exp_cyc += N - 1 - p;
      for (int v = 0; v < 16; v++) hist[v] = 0;
      for (int i = 0; i < N; i++) hist[blk[i]]++;
      pos = 0;
      for (int v = 0; v < 16; v++)
         for (int c = 0; c < hist[v]; c++) begin
            exp_sorted[pos] = v;
            pos++;
         end
   endtask

   task automatic load_block(input bit hold);
      for (int k = 0; k < N; k++) begin
         chk("in_ready_load", in_ready, 1);
         in_valid = 1'b1;
         in_data  = blk[k];
         @(posedge clk); #1;
      end
      if (hold) in_data = 4'hA;
      else      in_valid = 1'b0;
   endtask

   task automatic wait_sort(input bit hold);
      int cyc;
      cyc = 0;
      while (!out_valid && cyc < 200) begin
         chk("busy_sort", busy, 1);
         if (hold) chk("in_ready_sort", in_ready, 0);
         @(posedge clk); #1;
         cyc++;
      end
      chk("sort_cycles", cyc, exp_cyc);
      chk("swap_count_sort", swap_count, exp_swaps);
   endtask

   // bp: 0 = always ready, 1 = toggle 0/1, 2 = random stalls
   task automatic drain(input int bp, input bit hold);
      bit stall;
      for (int k = 0; k < N; k++) begin
         stall = (bp == 1) || (bp == 2 && $urandom_range(0, 1) == 1);
         if (stall) begin
            out_ready = 1'b0;
            @(posedge clk); #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, exp_sorted[k]);
         end
         chk("out_valid", out_valid, 1);
         chk("out_data", out_data, exp_sorted[k]);
         chk("out_last", out_last, (k == N - 1) ? 1 : 0);
         if (hold) chk("in_ready_drain", in_ready, 0);
         out_ready = 1'b1;
         if (k == N - 1) in_valid = 1'b0;
         @(posedge clk); #1;
         out_ready = 1'b0;
      end
      chk("valid_after", out_valid, 0);
      chk("busy_after", busy, 0);
      chk("in_ready_after", in_ready, 1);
      chk("swap_count_held", swap_count, exp_swaps);
   endtask

   task automatic run_block(input int a0, input int a1, input int a2, input int a3,
                            input int bp, input bit hold);
      blk[0] = 4'(a0); blk[1] = 4'(a1); blk[2] = 4'(a2); blk[3] = 4'(a3);
      compute_ref();
      load_block(hold);
      wait_sort(hold);
      drain(bp, hold);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_out_last"}, out_last, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_swap_count"}, swap_count, 0);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 4'h0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst = 1'b0;
      #1;
      chk("reset_in_ready", in_ready, 1);
      @(posedge clk); #1;

      // Directed blocks
      run_block(4, 3, 2, 1, 0, 1'b0);
      run_block(1, 2, 3, 4, 0, 1'b0);
      run_block(5, 5, 2, 5, 0, 1'b0);
      run_block(15, 0, 15, 0, 0, 1'b0);
      run_block(7, 1, 9, 3, 1, 1'b0);   // toggling backpressure
      run_block(2, 8, 8, 0, 0, 1'b1);   // in_valid held through SORT/DRAIN
      run_block(6, 0, 3, 12, 0, 1'b0);  // next block loads cleanly

      // Reset during SORT cycle 2
      blk[0] = 4'd4; blk[1] = 4'd3; blk[2] = 4'd2; blk[3] = 4'd1;
      load_block(1'b0);
      @(posedge clk); #1;
      chk("sort_before_rst", busy, 1);
      rst = 1'b1;
      #1;
      check_reset_values("midsort");
      chk("midsort_in_ready", in_ready, 0);
      #2;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("after_rst_in_ready", in_ready, 1);
      run_block(9, 8, 7, 6, 0, 1'b0);

      // Random blocks with random backpressure
      for (int t = 0; t < 25; t++) begin
         run_block($urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 15), $urandom_range(0, 15), 2, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_cmp_bubble_sorter
`default_nettype wire
